// File: rtl/mips_boot_loader_pkg.sv
// Shared definitions for the MIPS boot/run sequencer: FSM state encoding and the HALT word.
`default_nettype none
package mips_boot_loader_pkg;

  localparam logic [31:0] HALT_OPCODE_WORD = 32'hFC00_0000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_LOAD    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_RUN     = 3'd4,
    ST_DONE    = 3'd5,
    ST_ERR     = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mips_run_timer.sv
// Saturating RUN-cycle counter with synchronous clear, enable and a limit-reached flag.
`default_nettype none
module mips_run_timer #(
  parameter int unsigned LIMIT = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        enable,
  output logic [31:0] count,
  output logic        limit_hit
);

  localparam bit          HAS_LIMIT = (LIMIT != 0);
  localparam logic [31:0] LIMIT_M1  = 32'(LIMIT - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 32'd0;
    end else if (clear) begin
      count <= 32'd0;
    end else if (enable && (count != 32'hFFFF_FFFF)) begin
      count <= count + 32'd1;
    end
  end

  assign limit_hit = HAS_LIMIT && (count == LIMIT_M1);

endmodule
`default_nettype wire

// File: rtl/mips_boot_loader.sv
// Boot/run sequencer: holds the core in reset, streams a program into imem, then runs
// the core until HALT is fetched or the cycle limit expires.
`default_nettype none
module mips_boot_loader
  import mips_boot_loader_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 32,
  parameter logic [31:0] HALT_INSTR = HALT_OPCODE_WORD,
  parameter int unsigned RUN_LIMIT  = 1000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_reset,
  input  logic [31:0]       cpu_pc,
  input  logic [DATA_W-1:0] cpu_instr,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [31:0]       halt_pc,
  output logic [31:0]       cycle_cnt
);

  localparam logic [ADDR_W:0] DEPTH_W = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_W   = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state;
  logic [ADDR_W-1:0] wc;
  logic [ADDR_W-1:0] len_m1;
  logic [ADDR_W:0]   len_in;
  logic              start_ok;
  logic              halt_seen;
  logic              limit_hit;
  logic              timer_en;

  assign len_in    = s_data[ADDR_W:0];
  assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
  assign halt_seen = (cpu_instr == HALT_INSTR[DATA_W-1:0]);
  // Count only cycles that stay in RUN, so a timeout reports cycle_cnt == RUN_LIMIT-1.
  assign timer_en  = (state == ST_RUN) && !halt_seen && !limit_hit;

  assign s_ready   = (state == ST_LEN) || (state == ST_LOAD);
  assign busy      = (state == ST_LEN) || (state == ST_LOAD) ||
                     (state == ST_RELEASE) || (state == ST_RUN);
  assign done      = (state == ST_DONE);
  assign error     = (state == ST_ERR);
  assign cpu_reset = (state != ST_RUN);

  mips_run_timer #(
    .LIMIT(RUN_LIMIT)
  ) u_timer (
    .clk      (clk),
    .rst_n    (reset_n),
    .clear    (start_ok),
    .enable   (timer_en),
    .count    (cycle_cnt),
    .limit_hit(limit_hit)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      wc         <= '0;
      len_m1     <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      halt_pc    <= 32'd0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state   <= ST_LEN;
            halt_pc <= 32'd0;
          end
        end
        ST_LEN: begin
          if (s_valid) begin
            if ((len_in == '0) || (len_in > DEPTH_W)) begin
              state <= ST_ERR;
            end else begin
              len_m1 <= ADDR_W'(len_in - ONE_W);
              wc     <= '0;
              state  <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          // Each accepted word is written on the following cycle at its own index.
          if (s_valid) begin
            imem_we    <= 1'b1;
            imem_addr  <= wc;
            imem_wdata <= s_data;
            wc         <= wc + ADDR_W'(1);
            if (wc == len_m1) begin
              state <= ST_RELEASE;
            end
          end
        end
        ST_RELEASE: begin
          state <= ST_RUN;
        end
        ST_RUN: begin
          if (halt_seen) begin
            state   <= ST_DONE;
            halt_pc <= cpu_pc;
          end else if (limit_hit) begin
            state <= ST_ERR;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
